pc_fetch_ctrl: RTL

Parametrised program-counter and fetch-control block for the pipelined MIPS core's IF stage; successor to the plain PC register. It selects the next PC (sequential, taken branch, jump), honours hazard stalls, and supports continuous or single-step execution from the debug unit. It tracks a HALT instruction through a pipeline-drain phase and exposes a cycle counter for the debug unit.

---
 rtl/pc_fetch_pkg.sv | 26 ++
 rtl/step_edge_det.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
//   Shared definitions for the IF-stage fetch controller: the fetch FSM state
//   encoding and the default parameter values used by pc_fetch_ctrl.
//   No ports (package only).
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    // Fetch controller states. RUN fetches normally, DRAIN lets the pipeline
    // empty after a HALT, HALTED is terminal until reset.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_NB       = 32;
    localparam int unsigned DEFAULT_INC      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_DRAIN    = 4;
    localparam int unsigned DEFAULT_NB_CNT   = 32;

    // Drain counter width: holds DRAIN values 1..15.
    localparam int unsigned DRAIN_CNT_W = 4;

endpackage

// File: rtl/step_edge_det.sv
// -----------------------------------------------------------------------------
// step_edge_det
//   Registers a level input every cycle and produces a one-cycle rising-edge
//   pulse (level high now, low on the previous edge). Used for the debug
//   unit's single-step request.
//
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset (clears the history bit)
//     level  in   input level to watch
//     rise   out  level & ~previous level (combinational)
// -----------------------------------------------------------------------------
module step_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // A level held high for many cycles produces exactly one pulse; it must
    // drop for at least one edge before another pulse can occur.
    assign rise = level & ~level_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program counter and fetch control for the IF stage. Selects the next PC
//   (sequential / taken branch / jump), holds on hazard stalls, supports
//   continuous and single-step execution, drains the pipeline after a HALT
//   and counts enabled cycles for the debug unit.
//
//   Parameters:
//     NB        PC width
//     RESET_PC  PC value loaded on reset
//     INC       sequential increment
//     DRAIN     enabled ticks after HALT before reporting halted (1..15)
//     NB_CNT    cycle counter width
//
//   Ports:
//     i_clk            in   clock, rising edge
//     i_reset          in   asynchronous active-high reset
//     i_mode           in   0 = continuous, 1 = single-step
//     i_step           in   step request level (rising edge = one step)
//     i_pc_write       in   0 = hazard stall, hold PC
//     i_branch_taken   in   EX-stage taken branch
//     i_branch_target  in   branch target
//     i_jump           in   ID-stage jump
//     i_jump_target    in   jump target
//     i_halt           in   HALT decoded in ID
//     o_pc             out  current fetch address
//     o_pc_plus        out  o_pc + INC (combinational)
//     o_tick           out  pipeline enable for this cycle
//     o_halted         out  pipeline drained after HALT
//     o_cycle_count    out  enabled cycles since reset (saturating)
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     NB       = DEFAULT_NB,
    parameter logic [NB-1:0]   RESET_PC = NB'(DEFAULT_RESET_PC),
    parameter int unsigned     INC      = DEFAULT_INC,
    parameter int unsigned     DRAIN    = DEFAULT_DRAIN,
    parameter int unsigned     NB_CNT   = DEFAULT_NB_CNT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mode,
    input  logic              i_step,
    input  logic              i_pc_write,
    input  logic              i_branch_taken,
    input  logic [NB-1:0]     i_branch_target,
    input  logic              i_jump,
    input  logic [NB-1:0]     i_jump_target,
    input  logic              i_halt,
    output logic [NB-1:0]     o_pc,
    output logic [NB-1:0]     o_pc_plus,
    output logic              o_tick,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_count
);

    localparam int unsigned          CW      = DRAIN_CNT_W;
    localparam logic [NB-1:0]        INC_V   = NB'(INC);
    localparam logic [CW-1:0]        DRAIN_V = CW'(DRAIN);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);

    // Saturating increment for the cycle counter: sticks at all-ones.
    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        if (&v) begin
            return v;
        end
        return v + NB_CNT'(1);
    endfunction

    state_t              state;
    state_t              state_next;
    logic [NB-1:0]       pc;
    logic [NB-1:0]       pc_next;
    logic [NB-1:0]       pc_plus;
    logic [CW-1:0]       drain_cnt;
    logic [CW-1:0]       drain_next;
    logic [NB_CNT-1:0]   cycle_cnt;
    logic                step_rise;
    logic                tick;
    logic                tick_en;
    logic                halted;

    step_edge_det u_step_edge (
        .clk   (i_clk),
        .rst   (i_reset),
        .level (i_step),
        .rise  (step_rise)
    );

    // Continuous mode ticks every cycle; single-step only on a step edge.
    // Mode changes take effect in the same cycle since this is combinational.
    assign tick    = ~i_mode | step_rise;

    // Modulo-2^NB sequential address; wraps with no flag.
    assign pc_plus = pc + INC_V;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drain_cnt <= drain_next;
        end
    end

    // Next-state, next-PC and output decode
    always_comb begin
        state_next = state;
        pc_next    = pc;
        drain_next = drain_cnt;
        tick_en    = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_RUN: begin
                tick_en = tick;
                // A stall (i_pc_write=0) holds everything, including a
                // pending HALT or redirect; upstream keeps them stable.
                if (tick && i_pc_write) begin
                    if (i_branch_taken) begin
                        // A taken branch squashes a HALT in the same cycle.
                        pc_next = i_branch_target;
                    end else if (i_halt) begin
                        drain_next = DRAIN_V;
                        state_next = ST_DRAIN;
                    end else if (i_jump) begin
                        pc_next = i_jump_target;
                    end else begin
                        pc_next = pc_plus;
                    end
                end
            end

            ST_DRAIN: begin
                tick_en = tick;
                // PC frozen; redirects and HALT are ignored while draining.
                if (tick) begin
                    drain_next = drain_cnt - CNT_ONE;
                    if (drain_cnt <= CNT_ONE) begin
                        state_next = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Enabled-cycle counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycle_cnt <= '0;
        end else if (tick_en) begin
            cycle_cnt <= sat_inc(cycle_cnt);
        end
    end

    assign o_pc          = pc;
    assign o_pc_plus     = pc_plus;
    // The pipeline enable must stay low for the whole reset interval.
    assign o_tick        = tick_en & ~i_reset;
    assign o_halted      = halted;
    assign o_cycle_count = cycle_cnt;

endmodule
